// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Captures an 8-bit binary value, converts it to three BCD digits with a
//   sequential shift-add-3 (double-dabble) engine, then time-multiplexes the
//   digits onto a single downstream 7-segment decoder.
//
// Ports
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   valor    in   [7:0] unsigned value to display
//   carrega  in   load strobe, sampled on rising edge (ignored while busy)
//   digito   out  [7:0] decoder input: {4'b0, BCD} or 8'hFF for a blank digit
//   anodo    out  [2:0] active-low one-hot select: [0]=units [1]=tens [2]=hundreds
//   pronto   out  one-cycle pulse when a new value reaches the display
//   ocupado  out  high while a conversion is in progress

// Per-nibble double-dabble correction: a digit of 5 or more becomes >= 8
// after +3, so the following left shift carries it into the next decade.
module display_scan_nib_adj (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module display_scan_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_ZEROS = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] valor,
  input  logic       carrega,
  output logic [7:0] digito,
  output logic [2:0] anodo,
  output logic       pronto,
  output logic       ocupado
);

  localparam int NUM_NIB = 3;
  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} state_t;

  state_t                     state;
  logic [2:0]                 cnt;
  logic [7:0]                 shift;
  logic [NUM_NIB-1:0][3:0]    bcd;
  logic [NUM_NIB-1:0][3:0]    bcd_adj;
  logic [3:0]                 cent, dez, uni;
  logic [1:0]                 idx;
  logic [DIV_W-1:0]           div;
  logic                       blank_h, blank_t;

  // ---------------------------------------------------------------------------
  // BCD correction, one instance per decade
  // ---------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < NUM_NIB; g++) begin : g_adj
      display_scan_nib_adj u_adj (
        .nib (bcd[g]),
        .adj (bcd_adj[g])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Conversion FSM. The display registers only change in ATUALIZA, so the old
  // value stays visible for the whole conversion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= OCIOSO;
      cnt     <= '0;
      shift   <= '0;
      bcd     <= '0;
      cent    <= '0;
      dez     <= '0;
      uni     <= '0;
      pronto  <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (state)
        OCIOSO: begin
          if (carrega) begin
            shift   <= valor;
            bcd     <= '0;
            cnt     <= '0;
            ocupado <= 1'b1;
            state   <= CONVERTE;
          end
        end
        CONVERTE: begin
          // Correct then shift the whole {bcd, binary} register left by one.
          {bcd, shift} <= {bcd_adj, shift} << 1;
          cnt          <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ATUALIZA;
        end
        ATUALIZA: begin
          cent    <= bcd[2];
          dez     <= bcd[1];
          uni     <= bcd[0];
          pronto  <= 1'b1;
          ocupado <= 1'b0;
          state   <= OCIOSO;
        end
        default: begin
          ocupado <= 1'b0;
          state   <= OCIOSO;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan engine: free-running, independent of the FSM. Index walks 0->1->2->0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div == DIV_MAX) begin
      div <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select and value. Decoded purely from registers so anodo and digito
  // move together, and a new display value is visible in the edge it lands.
  // ---------------------------------------------------------------------------
  assign blank_h = (BLANK_ZEROS != 0) && (cent == 4'd0);
  assign blank_t = blank_h && (dez == 4'd0);

  always_comb begin
    anodo  = 3'b110;
    digito = {4'b0000, uni};
    case (idx)
      2'd1: begin
        anodo  = 3'b101;
        digito = blank_t ? 8'hFF : {4'b0000, dez};
      end
      2'd2: begin
        anodo  = 3'b011;
        digito = blank_h ? 8'hFF : {4'b0000, cent};
      end
      default: begin
        anodo  = 3'b110;
        digito = {4'b0000, uni};
      end
    endcase
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (leading-zero blanking on/off)
// share the same stimulus and are compared every cycle against a reference
// model built from decimal arithmetic and a load-to-display cycle count.
module tb_display_scan_ctrl;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] valor = 8'd0;
  logic       carrega = 1'b0;
  logic [7:0] digito_a, digito_b;
  logic [2:0] anodo_a, anodo_b;
  logic       pronto_a, pronto_b, ocupado_a, ocupado_b;

  int vectors = 0;
  int miscompares = 0;

  display_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_ZEROS(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .valor(valor), .carrega(carrega),
    .digito(digito_a), .anodo(anodo_a), .pronto(pronto_a), .ocupado(ocupado_a));

  display_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_ZEROS(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .valor(valor), .carrega(carrega),
    .digito(digito_b), .anodo(anodo_b), .pronto(pronto_b), .ocupado(ocupado_b));

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model: edges since reset drive the scan position; a load is
  // displayed 9 edges after it is accepted; loads are ignored while busy.
  // ---------------------------------------------------------------------------
  int m_cyc, m_phase, m_val, m_disp;
  bit m_pronto;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cyc = 0; m_phase = 0; m_disp = 0; m_pronto = 0;
    end else begin
      m_cyc++;
      m_pronto = 0;
      if (m_phase == 0) begin
        if (carrega) begin m_val = int'(valor); m_phase = 1; end
      end else if (m_phase < 9) begin
        m_phase++;
      end else begin
        m_disp = m_val; m_pronto = 1; m_phase = 0;
      end
    end
  end

  function automatic int m_idx();
    return (m_cyc / DIV) % 3;
  endfunction

  function automatic logic [2:0] exp_an(int ix);
    case (ix)
      1:       return 3'b101;
      2:       return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [7:0] exp_dig(int ix, int v, bit blank);
    int h, t, u;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    case (ix)
      1:       return (blank && h == 0 && t == 0) ? 8'hFF : 8'(t);
      2:       return (blank && h == 0) ? 8'hFF : 8'(h);
      default: return 8'(u);
    endcase
  endfunction

  function automatic logic [25:0] exp_vec();
    int ix;
    ix = m_idx();
    return {exp_an(ix), exp_an(ix), exp_dig(ix, m_disp, 1'b1), exp_dig(ix, m_disp, 1'b0),
            m_pronto, m_pronto, (m_phase != 0), (m_phase != 0)};
  endfunction

  // Drives a single-cycle load; returns at the falling edge after it was sampled.
  task automatic load_value(input logic [7:0] v);
    @(negedge clock);
    valor = v; carrega = 1'b1;
    @(negedge clock);
    carrega = 1'b0; valor = 8'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    vectors++;
    if ({anodo_a, digito_a, digito_b, pronto_a, ocupado_a} !== {3'b110, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got an=%b da=%h db=%h pr=%b oc=%b, want an=110 da=00 db=00 pr=0 oc=0",
               anodo_a, digito_a, digito_b, pronto_a, ocupado_a);
    end
    @(negedge clock) reset_n = 1'b1;
    load_value(8'd255);
    repeat (12) @(negedge clock);
    load_value(8'd77);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({anodo_a, digito_a, digito_b, pronto_a, ocupado_a} !== {3'b110, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got an=%b da=%h db=%h pr=%b oc=%b, want an=110 da=00 db=00 pr=0 oc=0",
               anodo_a, digito_a, digito_b, pronto_a, ocupado_a);
    end
    @(negedge clock) reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_scan_255();
    int n_pr, n_oc;
    n_pr = 0; n_oc = 0;
    load_value(8'd255);
    for (int i = 0; i < 30; i++) begin
      n_pr += int'(pronto_a);
      n_oc += int'(ocupado_a);
      vectors++;
      if ({anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b} !== exp_vec()) begin
        miscompares++;
        $display("FAIL scan_255 cyc %0d: got %h want %h", i,
                 {anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b}, exp_vec());
      end
      @(negedge clock);
    end
    vectors++;
    if (n_pr != 1 || n_oc != 9) begin
      miscompares++;
      $display("FAIL pulse_len_255: got pronto=%0d ocupado=%0d cycles, want 1 and 9", n_pr, n_oc);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_blanking();
    int vals[4] = '{9, 0, 100, 7};
    foreach (vals[k]) begin
      load_value(8'(vals[k]));
      for (int i = 0; i < 24; i++) begin
        vectors++;
        if ({anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b} !== exp_vec()) begin
          miscompares++;
          $display("FAIL blanking v=%0d cyc %0d: got %h want %h", vals[k], i,
                   {anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b}, exp_vec());
        end
        @(negedge clock);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ignore_busy();
    int n_pr;
    n_pr = 0;
    load_value(8'd42);
    valor = 8'd199; carrega = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (i == 3) carrega = 1'b0;
      n_pr += int'(pronto_a);
      vectors++;
      if ({anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b} !== exp_vec()) begin
        miscompares++;
        $display("FAIL ignore_busy cyc %0d: got %h want %h", i,
                 {anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b}, exp_vec());
      end
      @(negedge clock);
    end
    vectors++;
    if (n_pr != 1) begin
      miscompares++;
      $display("FAIL ignore_busy_pronto: got %0d pulses, want 1", n_pr);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int n_pr;
    n_pr = 0;
    load_value(8'd255);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      n_pr += int'(pronto_a);
      vectors++;
      if ({anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid cyc %0d: got %h want %h", i,
                 {anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b}, exp_vec());
      end
      @(negedge clock);
    end
    vectors++;
    if (n_pr != 0) begin
      miscompares++;
      $display("FAIL reset_mid_pronto: got %0d pulses, want 0", n_pr);
    end
    load_value(8'd128);
    for (int i = 0; i < 24; i++) begin
      vectors++;
      if ({anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reload_128 cyc %0d: got %h want %h", i,
                 {anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b}, exp_vec());
      end
      @(negedge clock);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [7:0] v;
    for (int k = 0; k < 16; k++) begin
      v = 8'($urandom);
      load_value(v);
      for (int i = 0; i < 10 + int'($urandom_range(0, 12)); i++) begin
        vectors++;
        if ({anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b} !== exp_vec()) begin
          miscompares++;
          $display("FAIL random v=%0d cyc %0d: got %h want %h", v, i,
                   {anodo_a, anodo_b, digito_a, digito_b, pronto_a, pronto_b, ocupado_a, ocupado_b}, exp_vec());
        end
        @(negedge clock);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_255();
    test_blanking();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
